fighter_sprite_engine: RTL and testbench

//  Parametrised per-fighter sprite renderer: one ROM holds every pose x animation frame.
//  - Sequences animation frames at the video frame rate.
//  - Applies pose, position and facing changes only at frame boundaries, so no tearing.
//  - Mirrors the sprite horizontally and keys out a transparent colour.
//  - Sits between the game-state FSM and the colour mapper: one instance per fighter, replacing the per-pose sprite mux.

---
 rtl/fighter_sprite_engine_pkg.sv | 27 ++
 rtl/fighter_sprite_engine_if.sv | 12 +
 rtl/fighter_sprite_engine_anim_ctrl.sv | 81 ++++++++
 rtl/fighter_sprite_engine.sv | 112 +++++++++++
 tb/tb_fighter_sprite_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fighter_sprite_engine_pkg.sv
// Shared constants for the fighter sprite engine: pose codes, the colour key
// and the width helpers used to size the ROM address and counters.
package fighter_sprite_engine_pkg;

    typedef enum logic [2:0] {
        POSE_STAND = 3'd0,
        PUNCH      = 3'd1,
        JUMP       = 3'd2,
        CROUCH     = 3'd3,
        WALK_L     = 3'd4,
        WALK_R     = 3'd5,
        DEATH      = 3'd6
    } pose_e;

    localparam logic [11:0] TRANSPARENT = 12'hF0F;

    // Never returns 0, so a parameter of 1 still yields a legal 1-bit vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_width(input int poses, input int frames,
                                      input int w, input int h);
        return clog2_min1(poses * frames * w * h);
    endfunction

endpackage

// File: rtl/fighter_sprite_engine_if.sv
// Sprite ROM bus: the engine drives the address, a synchronous ROM answers
// with {r,g,b} one cycle later.
interface fighter_sprite_engine_if #(
    parameter int ADDR_W = 18,
    parameter int DW     = 12
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DW-1:0]     rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/fighter_sprite_engine_anim_ctrl.sv
// Frame-boundary latch for pose, position and facing, plus the hold and
// animation-frame counters; nothing here moves except on frame_start.
module fighter_sprite_engine_anim_ctrl
    import fighter_sprite_engine_pkg::*;
#(
    parameter int NUM_POSES = 7,
    parameter int FRAMES    = 4,
    parameter int HOLD      = 6,
    parameter logic [NUM_POSES-1:0] ONESHOT_MASK = 7'h42,
    localparam int PW = clog2_min1(NUM_POSES),
    localparam int FW = clog2_min1(FRAMES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic [9:0]    pos_x_req,
    input  logic [9:0]    pos_y_req,
    input  logic [PW-1:0] pose_req,
    input  logic          flip_req,
    input  logic          restart,
    output logic [PW-1:0] cur_pose,
    output logic [FW-1:0] cur_frame,
    output logic [9:0]    pos_x,
    output logic [9:0]    pos_y,
    output logic          flip,
    output logic          anim_done
);

    localparam int HW = clog2_min1(HOLD);
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
    localparam logic [PW:0]   POSE_LIMIT = (PW + 1)'(NUM_POSES);

    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] pose_new;
    logic [FW-1:0] frame_next;
    logic          oneshot;

    // Out-of-range pose requests fall back to standing.
    assign pose_new   = ({1'b0, pose_req} >= POSE_LIMIT) ? '0 : pose_req;
    assign oneshot    = ONESHOT_MASK[cur_pose];
    assign frame_next = cur_frame + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_pose  <= '0;
            cur_frame <= '0;
            hold_cnt  <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            flip      <= 1'b0;
            anim_done <= 1'b0;
        end else begin
            anim_done <= 1'b0;
            if (frame_start) begin
                pos_x <= pos_x_req;
                pos_y <= pos_y_req;
                flip  <= flip_req;
                if ((pose_new != cur_pose) || restart) begin
                    cur_pose  <= pose_new;
                    cur_frame <= '0;
                    hold_cnt  <= '0;
                    // A single-frame one-shot is already on its last frame.
                    if ((FRAMES == 1) && ONESHOT_MASK[pose_new])
                        anim_done <= 1'b1;
                end else if (hold_cnt == HW'(HOLD - 1)) begin
                    hold_cnt <= '0;
                    if (cur_frame != LAST_FRAME) begin
                        cur_frame <= frame_next;
                        if (oneshot && (frame_next == LAST_FRAME))
                            anim_done <= 1'b1;
                    end else if (!oneshot) begin
                        cur_frame <= '0;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fighter_sprite_engine.sv
// Per-fighter sprite renderer: animation control plus a pixel pipeline that
// maps DrawX/DrawY to a ROM address, then keys and mirrors the returned colour.
module fighter_sprite_engine
    import fighter_sprite_engine_pkg::*;
#(
    parameter int NUM_POSES = 7,
    parameter int FRAMES    = 4,
    parameter int HOLD      = 6,
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 96,
    parameter int CB        = 4,
    parameter logic [NUM_POSES-1:0] ONESHOT_MASK = 7'h42,
    localparam int PW     = clog2_min1(NUM_POSES),
    localparam int FW     = clog2_min1(FRAMES),
    localparam int ADDR_W = addr_width(NUM_POSES, FRAMES, SPR_W, SPR_H)
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic [9:0]    PosX,
    input  logic [9:0]    PosY,
    input  logic [PW-1:0] pose_req,
    input  logic          flip_req,
    input  logic          restart,
    input  logic          blank,
    fighter_sprite_engine_if.master rom,
    output logic [CB-1:0] red,
    output logic [CB-1:0] green,
    output logic [CB-1:0] blue,
    output logic          sprite_on,
    output logic          anim_done,
    output logic [PW-1:0] cur_pose,
    output logic [FW-1:0] cur_frame
);

    localparam int DW = 3 * CB;
    localparam logic [DW-1:0] KEY = DW'(TRANSPARENT);

    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              flip;
    logic [10:0]       dx, dy, px, py, dx_off, dy_off, col_off;
    logic              in_box, in_box_q, in_box_d, blank_q, blank_d, opaque;
    logic [ADDR_W-1:0] addr_calc;

    fighter_sprite_engine_anim_ctrl #(
        .NUM_POSES    (NUM_POSES),
        .FRAMES       (FRAMES),
        .HOLD         (HOLD),
        .ONESHOT_MASK (ONESHOT_MASK)
    ) u_anim (
        .clk         (vga_clk),
        .rst_n       (reset_n),
        .frame_start (frame_start),
        .pos_x_req   (PosX),
        .pos_y_req   (PosY),
        .pose_req    (pose_req),
        .flip_req    (flip_req),
        .restart     (restart),
        .cur_pose    (cur_pose),
        .cur_frame   (cur_frame),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip        (flip),
        .anim_done   (anim_done)
    );

    // One extra bit keeps a sprite near x/y=1023 clipped instead of wrapping to 0.
    assign dx      = {1'b0, DrawX};
    assign dy      = {1'b0, DrawY};
    assign px      = {1'b0, pos_x};
    assign py      = {1'b0, pos_y};
    assign in_box  = (dx >= px) && (dx < px + 11'(SPR_W)) &&
                     (dy >= py) && (dy < py + 11'(SPR_H));
    assign dx_off  = dx - px;
    assign dy_off  = dy - py;
    assign col_off = flip ? (11'(SPR_W - 1) - dx_off) : dx_off;

    assign addr_calc = ((ADDR_W'(cur_pose) * ADDR_W'(FRAMES) + ADDR_W'(cur_frame))
                        * ADDR_W'(SPR_H) + ADDR_W'(dy_off)) * ADDR_W'(SPR_W)
                       + ADDR_W'(col_off);

    assign opaque = in_box_d && blank_d && (rom.rom_data != KEY);

    // Address -> ROM -> colour; in_box/blank ride along to meet rom_data.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom.rom_addr <= '0;
            in_box_q     <= 1'b0;
            blank_q      <= 1'b0;
            in_box_d     <= 1'b0;
            blank_d      <= 1'b0;
            sprite_on    <= 1'b0;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
        end else begin
            rom.rom_addr <= in_box ? addr_calc : '0;
            in_box_q     <= in_box;
            blank_q      <= blank;
            in_box_d     <= in_box_q;
            blank_d      <= blank_q;
            sprite_on    <= opaque;
            red          <= opaque ? rom.rom_data[3*CB-1:2*CB] : '0;
            green        <= opaque ? rom.rom_data[2*CB-1:CB]   : '0;
            blue         <= opaque ? rom.rom_data[CB-1:0]      : '0;
        end
    end

endmodule

// File: tb/tb_fighter_sprite_engine.sv
// Directed bench for fighter_sprite_engine with a behavioural synchronous ROM
// whose contents are a fixed function of the address.
module tb_fighter_sprite_engine;
    import fighter_sprite_engine_pkg::*;

    localparam int AW = addr_width(7, 4, 64, 96);

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0, PosX = '0, PosY = '0;
    logic [2:0] pose_req = '0;
    logic       flip_req = 1'b0, restart = 1'b0, blank = 1'b0;
    logic [3:0] red, green, blue;
    logic       sprite_on, anim_done;
    logic [2:0] cur_pose;
    logic [1:0] cur_frame;
    logic       rom_force = 1'b0;
    logic [11:0] rom_force_val = 12'h000;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int done_base;

    fighter_sprite_engine_if #(.ADDR_W(AW), .DW(12)) rom_bus ();

    fighter_sprite_engine #(
        .NUM_POSES(7), .FRAMES(4), .HOLD(6), .SPR_W(64), .SPR_H(96),
        .CB(4), .ONESHOT_MASK(7'h42)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
        .pose_req(pose_req), .flip_req(flip_req), .restart(restart),
        .blank(blank), .rom(rom_bus), .red(red), .green(green), .blue(blue),
        .sprite_on(sprite_on), .anim_done(anim_done),
        .cur_pose(cur_pose), .cur_frame(cur_frame)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [11:0] rom_pattern(input logic [AW-1:0] a);
        return a[11:0] ^ 12'h321;
    endfunction

    always @(posedge vga_clk)
        rom_bus.rom_data <= rom_force ? rom_force_val : rom_pattern(rom_bus.rom_addr);

    always @(negedge vga_clk)
        if (anim_done === 1'b1) done_total <= done_total + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic b);
        DrawX = x;
        DrawY = y;
        blank = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic check_pixel(input string tag, input logic on, input logic [11:0] rgb);
        checkOutput({tag, "_on"}, 32'(sprite_on), 32'(on));
        checkOutput({tag, "_rgb"}, 32'({red, green, blue}), 32'(rgb));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("rst_addr", 32'(rom_bus.rom_addr), 0);
        checkOutput("rst_pose", 32'(cur_pose), 0);
        checkOutput("rst_frame", 32'(cur_frame), 0);
        check_pixel("rst_pix", 1'b0, 12'h000);
        checkOutput("rst_done", 32'(anim_done), 0);
        reset_n = 1'b1;
        tick();

        // Looping stand pose: one frame advance per six frame_start pulses
        pose_req = POSE_STAND;
        done_base = done_total;
        for (int p = 1; p <= 36; p++) begin
            pulse_frame();
            checkOutput($sformatf("loop_frame_p%0d", p), 32'(cur_frame), 32'((p / 6) % 4));
        end
        checkOutput("loop_no_done", 32'(done_total - done_base), 0);

        // One-shot punch from frame 2 of stand
        pose_req = PUNCH;
        done_base = done_total;
        pulse_frame();
        checkOutput("punch_pose", 32'(cur_pose), 1);
        checkOutput("punch_frame0", 32'(cur_frame), 0);
        for (int k = 1; k <= 17; k++) pulse_frame();
        checkOutput("punch_frame2", 32'(cur_frame), 2);
        checkOutput("punch_done_pre", 32'(done_total - done_base), 0);
        pulse_frame();
        checkOutput("punch_frame3", 32'(cur_frame), 3);
        checkOutput("punch_done_once", 32'(done_total - done_base), 1);
        for (int k = 0; k < 300; k++) pulse_frame();
        checkOutput("punch_hold3", 32'(cur_frame), 3);
        checkOutput("punch_done_total", 32'(done_total - done_base), 1);

        // Address and colour, unmirrored then mirrored (pose 1, frame 3 base 43008)
        PosX = 10'd100;
        PosY = 10'd200;
        flip_req = 1'b0;
        pulse_frame();
        applyStimulus(10'd100, 10'd200, 1'b1);
        tick();
        checkOutput("addr_noflip", 32'(rom_bus.rom_addr), 43008);
        tick();
        tick();
        check_pixel("pix_noflip", 1'b1, rom_pattern(AW'(43008)));
        flip_req = 1'b1;
        pulse_frame();
        tick();
        checkOutput("addr_flip", 32'(rom_bus.rom_addr), 43071);
        tick();
        tick();
        check_pixel("pix_flip", 1'b1, rom_pattern(AW'(43071)));
        applyStimulus(10'd110, 10'd205, 1'b1);
        tick();
        checkOutput("addr_flip_mid", 32'(rom_bus.rom_addr), 43381);

        // Mid-frame requests must wait for frame_start
        pose_req = CROUCH;
        PosX = 10'd300;
        flip_req = 1'b0;
        tick();
        tick();
        checkOutput("mid_pose", 32'(cur_pose), 1);
        checkOutput("mid_frame", 32'(cur_frame), 3);
        checkOutput("mid_addr", 32'(rom_bus.rom_addr), 43381);
        pulse_frame();
        checkOutput("new_pose", 32'(cur_pose), 3);
        checkOutput("new_frame", 32'(cur_frame), 0);
        checkOutput("new_addr_outside", 32'(rom_bus.rom_addr), 0);
        applyStimulus(10'd300, 10'd200, 1'b1);
        tick();
        checkOutput("new_addr", 32'(rom_bus.rom_addr), 73728);

        // Sprite at the right edge: clipped, no wrap to DrawX 0..39
        PosX = 10'd1000;
        PosY = 10'd0;
        pulse_frame();
        applyStimulus(10'd1023, 10'd10, 1'b1);
        tick();
        checkOutput("edge_addr", 32'(rom_bus.rom_addr), 74391);
        tick();
        tick();
        check_pixel("edge_pix", 1'b1, rom_pattern(AW'(74391)));
        applyStimulus(10'd0, 10'd10, 1'b1);
        tick();
        tick();
        tick();
        for (int x = 0; x < 40; x++) begin
            applyStimulus(10'(x), 10'd10, 1'b1);
            tick();
            checkOutput($sformatf("wrap_addr_x%0d", x), 32'(rom_bus.rom_addr), 0);
            checkOutput($sformatf("wrap_on_x%0d", x), 32'(sprite_on), 0);
        end

        // Colour key and blanking
        applyStimulus(10'd1010, 10'd10, 1'b1);
        rom_force = 1'b1;
        rom_force_val = 12'hF0F;
        tick();
        tick();
        tick();
        check_pixel("key_pix", 1'b0, 12'h000);
        rom_force = 1'b0;
        blank = 1'b0;
        tick();
        tick();
        tick();
        check_pixel("blank_pix", 1'b0, 12'h000);
        blank = 1'b1;
        tick();
        tick();
        tick();
        check_pixel("vis_pix", 1'b1, rom_pattern(AW'(74378)));

        // Asynchronous reset mid-line
        reset_n = 1'b0;
        #1;
        check_pixel("arst_pix", 1'b0, 12'h000);
        checkOutput("arst_addr", 32'(rom_bus.rom_addr), 0);
        checkOutput("arst_pose", 32'(cur_pose), 0);
        checkOutput("arst_frame", 32'(cur_frame), 0);
        pose_req = POSE_STAND;
        tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) pulse_frame();
        checkOutput("post_rst_hold5", 32'(cur_frame), 0);
        pulse_frame();
        checkOutput("post_rst_hold6", 32'(cur_frame), 1);

        // Restart returns to frame 0 and clears the hold count
        restart = 1'b1;
        pulse_frame();
        restart = 1'b0;
        checkOutput("restart_frame", 32'(cur_frame), 0);
        for (int k = 0; k < 5; k++) pulse_frame();
        checkOutput("restart_hold5", 32'(cur_frame), 0);
        pulse_frame();
        checkOutput("restart_hold6", 32'(cur_frame), 1);

        // Pose selection edge cases
        pose_req = WALK_R;
        pulse_frame();
        checkOutput("walk_pose", 32'(cur_pose), 5);
        pose_req = 3'd7;
        pulse_frame();
        checkOutput("oob_pose", 32'(cur_pose), 0);
        pose_req = DEATH;
        restart = 1'b1;
        pulse_frame();
        restart = 1'b0;
        checkOutput("death_pose", 32'(cur_pose), 6);
        checkOutput("death_frame", 32'(cur_frame), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
